// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode.
// Results carry the CORDIC gain K; the arctan increment comes from an external ROM indexed by iter.
module cordic_iter_engine #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [17:0]      z_in,
    output logic [4:0]              iter,
    input  logic [15:0]             gamma,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH+1:0] x_out,
    output logic signed [WIDTH+1:0] y_out,
    output logic signed [17:0]      z_out
);

    localparam int XW = WIDTH + 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

    logic [1:0]           r_state;
    logic                 r_mode;
    logic [4:0]           r_iter;
    logic signed [XW-1:0] r_x;
    logic signed [XW-1:0] r_y;
    logic signed [17:0]   r_z;

    logic signed [XW-1:0] w_x_sh;
    logic signed [XW-1:0] w_y_sh;
    logic signed [17:0]   w_gamma_ext;
    logic                 w_dir_pos;
    logic signed [XW-1:0] w_x_next;
    logic signed [XW-1:0] w_y_next;
    logic signed [17:0]   w_z_next;

    // d = +1 drives z toward zero in rotation mode and y toward zero in vectoring mode
    assign w_dir_pos   = r_mode ? r_y[XW-1] : ~r_z[17];
    assign w_x_sh      = r_x >>> r_iter;
    assign w_y_sh      = r_y >>> r_iter;
    assign w_gamma_ext = $signed({2'b00, gamma});

    assign w_x_next = w_dir_pos ? (r_x - w_y_sh) : (r_x + w_y_sh);
    assign w_y_next = w_dir_pos ? (r_y + w_x_sh) : (r_y - w_x_sh);
    assign w_z_next = w_dir_pos ? (r_z - w_gamma_ext) : (r_z + w_gamma_ext);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_iter  <= 5'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x     <= {{2{x_in[WIDTH-1]}}, x_in};
                        r_y     <= {{2{y_in[WIDTH-1]}}, y_in};
                        r_z     <= z_in;
                        r_mode  <= mode;
                        r_iter  <= 5'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x <= w_x_next;
                    r_y <= w_y_next;
                    r_z <= w_z_next;
                    if (r_iter == LAST_ITER) begin
                        r_iter  <= 5'd0;
                        r_state <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign iter      = r_iter;
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign z_out     = r_z;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine: rotation/vectoring vectors, backpressure,
// ROM index sequencing, short ITERS build and mid-run reset.
module tb_cordic_iter_engine;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic mode = 1'b0;
    logic out_ready = 1'b0;
    logic signed [W-1:0] x_in = '0;
    logic signed [W-1:0] y_in = '0;
    logic signed [17:0]  z_in = '0;

    logic                in_ready, out_valid;
    logic [4:0]          iter;
    logic [15:0]         gamma;
    logic signed [W+1:0] x_out, y_out;
    logic signed [17:0]  z_out;

    logic                in_valid4 = 1'b0;
    logic                out_ready4 = 1'b1;
    logic                in_ready4, out_valid4;
    logic [4:0]          iter4;
    logic [15:0]         gamma4;
    logic signed [W+1:0] x_out4, y_out4;
    logic signed [17:0]  z_out4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // atan(2^-i) in units of 90deg/65536, rounded
    function automatic logic [15:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:  return 16'd32768;
            5'd1:  return 16'd19344;
            5'd2:  return 16'd10221;
            5'd3:  return 16'd5188;
            5'd4:  return 16'd2604;
            5'd5:  return 16'd1303;
            5'd6:  return 16'd652;
            5'd7:  return 16'd326;
            5'd8:  return 16'd163;
            5'd9:  return 16'd81;
            5'd10: return 16'd41;
            5'd11: return 16'd20;
            5'd12: return 16'd10;
            5'd13: return 16'd5;
            5'd14: return 16'd3;
            5'd15: return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    assign gamma  = atan_lut(iter);
    assign gamma4 = atan_lut(iter4);

    cordic_iter_engine #(.WIDTH(W), .ITERS(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .iter(iter), .gamma(gamma), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    cordic_iter_engine #(.WIDTH(W), .ITERS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .mode(mode), .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .iter(iter4), .gamma(gamma4), .out_valid(out_valid4), .out_ready(out_ready4),
        .x_out(x_out4), .y_out(y_out4), .z_out(z_out4)
    );

    task automatic check_val(input string tag, input int got, input int exp, input int tol);
        int diff;
        diff = got - exp;
        n_checks++;
        if (diff <= tol && diff >= -tol) begin
            n_pass++;
            $display("check %-14s got %0d expected %0d (tol %0d) ok", tag, got, exp, tol);
        end else begin
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand, then walk RUN checking the ROM index and the latency
    task automatic run_op(input logic m, input int xi, input int yi, input int zi);
        int k;
        int bad;
        check_val("in_ready_pre", int'(in_ready), 1, 0);
        in_valid = 1'b1;
        mode     = m;
        x_in     = W'(xi);
        y_in     = W'(yi);
        z_in     = 18'(zi);
        tick();
        in_valid = 1'b0;
        x_in     = 16'sh5a5a;
        y_in     = -16'sh1234;
        z_in     = 18'sh2beef;
        mode     = ~m;
        k = 0;
        bad = 0;
        while (!out_valid && k < 40) begin
            if (iter != k[4:0] || in_ready) bad++;
            tick();
            k++;
        end
        check_val("latency", k, 16, 0);
        check_val("iter_seq", bad, 0, 0);
        check_val("iter_done", int'(iter), 0, 0);
    endtask

    task automatic release_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("out_valid_rel", int'(out_valid), 0, 0);
        check_val("in_ready_rel", int'(in_ready), 1, 0);
    endtask

    initial begin
        int k;
        int changed;
        int busy;
        int sx, sy, sz;

        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", int'(in_ready), 1, 0);
        check_val("rst_out_valid", int'(out_valid), 0, 0);
        check_val("rst_iter", int'(iter), 0, 0);
        check_val("rst_x", int'(x_out), 0, 0);
        check_val("rst_y", int'(y_out), 0, 0);
        check_val("rst_z", int'(z_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // rotation by 0deg: bit-exact hand-traced result
        run_op(1'b0, 16'h4000, 0, 0);
        check_val("rot0_x", int'(x_out), 26982, 0);
        check_val("rot0_y", int'(y_out), 1, 0);
        check_val("rot0_z", int'(z_out), 0, 0);
        release_op();

        // rotation by +90deg, then 5 cycles of backpressure with ignored in_valid pulses
        run_op(1'b0, 16'h4000, 0, 18'h10000);
        check_val("rot90_x", int'(x_out), 0, 4);
        check_val("rot90_y", int'(y_out), 26981, 4);
        check_val("rot90_z", int'(z_out), 0, 4);
        sx = int'(x_out);
        sy = int'(y_out);
        sz = int'(z_out);
        changed = 0;
        busy = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            x_in = 16'sh1111;
            z_in = 18'sh00100;
            tick();
            if (int'(x_out) != sx || int'(y_out) != sy || int'(z_out) != sz || !out_valid) changed++;
            if (in_ready) busy++;
        end
        in_valid = 1'b0;
        check_val("bp_stable", changed, 0, 0);
        check_val("bp_in_ready", busy, 0, 0);
        release_op();
        tick();
        tick();
        check_val("no_queue_valid", int'(out_valid), 0, 0);
        check_val("no_queue_iter", int'(iter), 0, 0);

        // vectoring of a 45deg vector
        run_op(1'b1, 16'h4000, 16'h4000, 0);
        check_val("vec45_x", int'(x_out), 38157, 4);
        check_val("vec45_y", int'(y_out), 0, 4);
        check_val("vec45_z", int'(z_out), 18'h08000, 4);
        release_op();

        // ITERS = 4 build: latency and bit-exact partial rotation
        check_val("i4_in_ready", int'(in_ready4), 1, 0);
        in_valid4 = 1'b1;
        mode = 1'b0;
        x_in = 16'sh4000;
        y_in = '0;
        z_in = '0;
        tick();
        in_valid4 = 1'b0;
        k = 0;
        while (!out_valid4 && k < 40) begin
            tick();
            k++;
        end
        check_val("i4_latency", k, 4, 0);
        check_val("i4_x", int'(x_out4), 26880, 0);
        check_val("i4_y", int'(y_out4), -1280, 0);
        check_val("i4_z", int'(z_out4), 1985, 0);
        tick();
        check_val("i4_ready_after", int'(in_ready4), 1, 0);

        // abort mid-RUN at iteration 7
        in_valid = 1'b1;
        mode = 1'b0;
        x_in = 16'sh4000;
        y_in = '0;
        z_in = '0;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (iter != 5'd7 && k < 40) begin
            tick();
            k++;
        end
        check_val("mid_reach_it7", int'(iter), 7, 0);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", int'(out_valid), 0, 0);
        check_val("mid_rst_ready", int'(in_ready), 1, 0);
        check_val("mid_rst_iter", int'(iter), 0, 0);
        check_val("mid_rst_x", int'(x_out), 0, 0);
        check_val("mid_rst_y", int'(y_out), 0, 0);
        check_val("mid_rst_z", int'(z_out), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("post_rst_ready", int'(in_ready), 1, 0);
        check_val("post_rst_valid", int'(out_valid), 0, 0);
        run_op(1'b0, 16'h4000, 0, 0);
        check_val("post_rst_x", int'(x_out), 26982, 0);
        check_val("post_rst_y", int'(y_out), 1, 0);
        check_val("post_rst_z", int'(z_out), 0, 0);
        release_op();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
